// File: rtl/cache_dp_fill_ctrl.sv
// cache_dp_fill_ctrl: single-outstanding lookup/fill controller in front of the dual-port cache.
// Latency: hit response 2 cycles after accept; miss response 2 cycles after the memory data beat.
// Backpressure: holds the mem request and the client response stable until the matching ready.
// Optional feature macro: CACHE_FILL_VALID_TRACK_EN (per-index valid bits gate port-B hits).

module cache_dp_fill_ctrl #(
    parameter int IDX_BITS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,

    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  resp_hit_o,

    output logic [ADDR_WIDTH-1:0] cache_addra_o,
    output logic [ADDR_WIDTH-1:0] cache_addrb_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    output logic                  cache_cea_o,
    output logic                  cache_ceb_o,
    output logic                  cache_we_o,
    input  logic [DATA_WIDTH-1:0] cache_rdatab_i,
    input  logic                  cache_rhitb_i,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,

    output logic [15:0]           hit_count_o,
    output logic [15:0]           miss_count_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_FILL     = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hit_q, hit_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;

    // Output strobes are flopped from the next state so they line up with the state they belong to
    logic                  req_rdy_q, req_rdy_d;
    logic                  ceb_q, ceb_d;
    logic                  fill_q, fill_d;
    logic                  mem_vld_q, mem_vld_d;
    logic                  resp_vld_q, resp_vld_d;

    logic                  lookup_hit;

`ifdef CACHE_FILL_VALID_TRACK_EN
    localparam int N_LINES = 2**IDX_BITS;

    logic [N_LINES-1:0] line_vld_q, line_vld_d;

    // A line becomes trustworthy only once this controller has filled it since reset
    always_comb begin
        line_vld_d = line_vld_q;
        if (state_q == S_FILL) begin
            line_vld_d[addr_q[IDX_BITS-1:0]] = 1'b1;
        end
    end

    // Valid bits are wiped by reset so stale zeroed cache entries cannot hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_vld_q <= '0;
        end else begin
            line_vld_q <= line_vld_d;
        end
    end

    assign lookup_hit = cache_rhitb_i & line_vld_q[addr_q[IDX_BITS-1:0]];
`else
    // Tag match alone decides; an untouched entry with tag 0 hits with data 0
    assign lookup_hit = cache_rhitb_i;
`endif

    // Next-state, datapath capture and saturating statistics
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        hit_d      = hit_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        case (state_q)
            S_IDLE: begin
                // req_rdy_q is low for the first cycle after reset, so accept only when advertised
                if (req_valid_i && req_rdy_q) begin
                    addr_d  = req_addr_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    data_d    = cache_rdatab_i;
                    hit_d     = 1'b1;
                    hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                    state_d   = S_RESP;
                end else begin
                    hit_d      = 1'b0;
                    miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                    state_d    = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                // Memory data is only meaningful here; stray beats elsewhere are dropped
                if (mem_rsp_valid_i) begin
                    data_d  = mem_rsp_data_i;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // Single write cycle; the line is readable by the next request
                hit_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered output strobes decoded from the upcoming state
    always_comb begin
        req_rdy_d  = (state_d == S_IDLE);
        ceb_d      = (state_d == S_LOOKUP);
        mem_vld_d  = (state_d == S_MEM_REQ);
        fill_d     = (state_d == S_FILL);
        resp_vld_d = (state_d == S_RESP);
    end

    // Controller state and registered outputs; reset abandons any in-flight memory transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            req_rdy_q  <= 1'b0;
            ceb_q      <= 1'b0;
            fill_q     <= 1'b0;
            mem_vld_q  <= 1'b0;
            resp_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hit_q      <= hit_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            req_rdy_q  <= req_rdy_d;
            ceb_q      <= ceb_d;
            fill_q     <= fill_d;
            mem_vld_q  <= mem_vld_d;
            resp_vld_q <= resp_vld_d;
        end
    end

    assign req_ready_o     = req_rdy_q;
    assign resp_valid_o    = resp_vld_q;
    assign resp_data_o     = data_q;
    assign resp_hit_o      = hit_q;

    // Both cache ports and the memory address track the latched request address in every state
    assign cache_addra_o   = addr_q;
    assign cache_addrb_o   = addr_q;
    assign cache_wdata_o   = data_q;
    assign cache_cea_o     = fill_q;
    assign cache_we_o      = fill_q;
    assign cache_ceb_o     = ceb_q;

    assign mem_req_valid_o = mem_vld_q;
    assign mem_addr_o      = addr_q;

    assign hit_count_o     = hit_cnt_q;
    assign miss_count_o    = miss_cnt_q;

endmodule
